instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Program sequencer that sits directly upstream of the instruction ROM and downstream of it in the same loop. It owns the program counter and drives the ROM address, then registers the returned 28-bit instruction for the decode stage. It applies jump, call and return redirects issued by decode, and keeps a hardware return-address stack for nested CALL/RET.

## Interface
- ADDR_W, 16, program counter and ROM address width
- INSTR_W, 28, instruction width
- STACK_DEPTH, 8, return-address stack entries (power of two, ≥2)

- Clock  in  1  system clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low; asserted (0) forces the reset state immediately
- oAddress  out  ADDR_W  ROM address; combinational copy of the PC register
- iInstruction  in  INSTR_W  ROM data for oAddress; combinational, same cycle
- oInstruction  out  INSTR_W  registered instruction for decode
- oInstrPC  out  ADDR_W  address from which oInstruction was fetched
- oValid  out  1  oInstruction is on the correct path
- iStall  in  1  decode back-pressure; freezes the unit
- iJump  in  1  redirect PC to iTarget
- iCall  in  1  push return address, redirect to iTarget
- iRet  in  1  pop return address into PC
- iTarget  in  ADDR_W  jump/call destination
- oStackErr  out  1  sticky overflow/underflow flag
- oDepth  out  clog2(STACK_DEPTH)+1  current stack occupancy

## Operation
- Reset (Reset=0): PC=0, oInstruction=0, oInstrPC=0, oValid=0, stack empty (oDepth=0), oStackErr=0. oAddress=0 throughout.
- Redirect inputs (iJump/iCall/iRet) refer to the instruction currently on oInstruction. They are honoured only when oValid=1 and iStall=0. Otherwise they are ignored.
- Priority when more than one is asserted: iRet > iCall > iJump.
- Normal cycle (iStall=0, no honoured redirect): oInstruction<=iInstruction, oInstrPC<=PC, oValid<=1, PC<=PC+1.
- Jump: PC<=iTarget, oValid<=0. The instruction fetched this cycle is squashed, costing a 1-cycle bubble.
- Call: push oInstrPC+1, PC<=iTarget, oValid<=0, oDepth+1.
  - If the stack is full (oDepth=STACK_DEPTH): the push is dropped, the stack is unchanged, oStackErr<=1, and the PC still redirects.
- Ret: PC<=top of stack, pop, oValid<=0, oDepth-1.
  - If the stack is empty: PC<=0, oDepth stays 0, oStackErr<=1.
- Stall (iStall=1): PC, oInstruction, oInstrPC, oValid, stack and oStackErr all hold.
- Arithmetic: PC+1 and oInstrPC+1 are modulo 2^ADDR_W, so 16'hFFFF wraps to 0. The stack is a LIFO array with a pointer. Entry contents are not reset, only the pointer.
- oStackErr clears only on reset.

## Timing
- ROM is combinational: iInstruction is valid in the same cycle that oAddress changes.
- Fetch-to-decode latency is 1 cycle. The first instruction (address 0) appears on oInstruction with oValid=1 after the first rising edge following Reset deassertion.
- Redirect penalty is exactly 1 cycle with oValid=0. The target instruction is on oInstruction 2 edges after the redirect edge's input cycle, i.e. the edge after the bubble.
- Straight-line throughput is 1 instruction per cycle.
- A Reset assertion mid-operation clears state asynchronously, without waiting for a clock edge, including during a stall or bubble.
- Stall has no latency: the outputs are identical on the edge where iStall=1 is sampled.

## Test plan
- Sequential fetch: release reset with the ROM model returning {4'h0,addr}. Required: oInstrPC = 0,1,2,3… on consecutive edges, oValid=1 from the first edge, and oInstruction matches each address.
- Jump: iJump=1, iTarget=15 while oInstrPC=16. Required: one oValid=0 cycle, then oInstrPC=15, 16, 15… looping.
- Nested call/ret: call 17 from 5, then call 30 from 18, ret, ret. Required: oDepth goes 1→2→1→0, and execution resumes at 19 and then at 6, each after one bubble.
- Overflow/underflow:
  - STACK_DEPTH+1 calls: the ninth call still redirects, oStackErr=1, oDepth=8.
  - Separately, a ret from reset: PC=0, oStackErr=1, oDepth=0.
- Stall: iStall=1 for 3 cycles with iJump also asserted. Required: all outputs frozen and the jump ignored; fetch resumes at the next sequential address on release.
- Reset mid-run: assert Reset between edges at PC=40 with oDepth=2. Required: oAddress=0, oValid=0, oDepth=0 and oStackErr=0 immediately, and fetch restarts at 0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Bus between the fetch unit and its neighbours: ROM address/data,
// the registered decode-side instruction, redirect requests and stack status.
interface instr_fetch_unit_if #(
   parameter int ADDR_W      = 16,
   parameter int INSTR_W     = 28,
   parameter int STACK_DEPTH = 8
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

   logic [ADDR_W-1:0]  oAddress;
   logic [INSTR_W-1:0] iInstruction;
   logic [INSTR_W-1:0] oInstruction;
   logic [ADDR_W-1:0]  oInstrPC;
   logic               oValid;
   logic               iStall;
   logic               iJump;
   logic               iCall;
   logic               iRet;
   logic [ADDR_W-1:0]  iTarget;
   logic               oStackErr;
   logic [DEPTH_W-1:0] oDepth;

   modport master (
      output oAddress, oInstruction, oInstrPC, oValid, oStackErr, oDepth,
      input  iInstruction, iStall, iJump, iCall, iRet, iTarget
   );

   modport slave (
      input  oAddress, oInstruction, oInstrPC, oValid, oStackErr, oDepth,
      output iInstruction, iStall, iJump, iCall, iRet, iTarget
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program sequencer: owns the PC, registers ROM data for decode, and applies
// jump/call/ret redirects with a hardware return-address stack.
module instr_fetch_unit #(
   parameter int ADDR_W      = 16,
   parameter int INSTR_W     = 28,
   parameter int STACK_DEPTH = 8
) (
   input logic                Clock,
   input logic                Reset,
   instr_fetch_unit_if.master bus
);
   localparam int PTR_W   = $clog2(STACK_DEPTH);
   localparam int DEPTH_W = PTR_W + 1;
   localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

   logic [ADDR_W-1:0]  pc;
   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  instr_pc;
   logic               valid;
   logic               stack_err;
   logic [DEPTH_W-1:0] depth;
   logic [ADDR_W-1:0]  stack [STACK_DEPTH];

   logic               honoured;
   logic               do_ret;
   logic               do_call;
   logic               do_jump;
   logic               stack_full;
   logic               stack_empty;
   logic [PTR_W-1:0]   push_idx;
   logic [PTR_W-1:0]   top_idx;

   // Redirects belong to the instruction on the decode side, so a bubble or a
   // stall makes them meaningless; the priority chain is ret, call, jump.
   assign honoured    = valid & ~bus.iStall;
   assign do_ret      = honoured & bus.iRet;
   assign do_call     = honoured & bus.iCall & ~bus.iRet;
   assign do_jump     = honoured & bus.iJump & ~bus.iCall & ~bus.iRet;
   assign stack_full  = (depth == FULL);
   assign stack_empty = (depth == '0);
   assign push_idx    = depth[PTR_W-1:0];
   assign top_idx     = depth[PTR_W-1:0] - PTR_W'(1);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         pc        <= '0;
         instr     <= '0;
         instr_pc  <= '0;
         valid     <= 1'b0;
         stack_err <= 1'b0;
         depth     <= '0;
      end else if (!bus.iStall) begin
         if (do_ret) begin
            valid <= 1'b0;
            if (stack_empty) begin
               pc        <= '0;
               stack_err <= 1'b1;
            end else begin
               pc    <= stack[top_idx];
               depth <= depth - DEPTH_W'(1);
            end
         end else if (do_call) begin
            pc    <= bus.iTarget;
            valid <= 1'b0;
            if (stack_full) begin
               stack_err <= 1'b1;
            end else begin
               depth <= depth + DEPTH_W'(1);
            end
         end else if (do_jump) begin
            pc    <= bus.iTarget;
            valid <= 1'b0;
         end else begin
            instr    <= bus.iInstruction;
            instr_pc <= pc;
            valid    <= 1'b1;
            pc       <= pc + ADDR_W'(1);
         end
      end
   end

   // Stack contents are plain storage; only the pointer is reset.
   always_ff @(posedge Clock) begin
      if (Reset && do_call && !stack_full) begin
         stack[push_idx] <= instr_pc + ADDR_W'(1);
      end
   end

   assign bus.oAddress     = pc;
   assign bus.oInstruction = instr;
   assign bus.oInstrPC     = instr_pc;
   assign bus.oValid       = valid;
   assign bus.oStackErr    = stack_err;
   assign bus.oDepth       = depth;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a queue-based program-flow model
// predicts every cycle's outputs under directed and random redirects.
module tb_instr_fetch_unit;
   logic Clock;
   logic Reset;
   int   n_cmp;
   int   n_fail;
   logic [3:0] salt;

   instr_fetch_unit_if bus ();

   instr_fetch_unit dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.master)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [27:0] rom(input logic [15:0] a);
      return {a[3:0] ^ salt, a};
   endfunction

   assign bus.iInstruction = rom(bus.oAddress);

   // Behavioural model of the program flow
   logic [15:0] m_pc;
   logic [15:0] m_ipc;
   logic [27:0] m_instr;
   logic        m_valid;
   logic        m_err;
   logic [15:0] stk[$];

   task automatic model_reset();
      m_pc = 16'd0; m_ipc = 16'd0; m_instr = 28'd0;
      m_valid = 1'b0; m_err = 1'b0;
      stk.delete();
   endtask

   // Drives one cycle of stimulus, advances the model, samples after the edge
   task automatic step(input logic s, input logic j, input logic c, input logic r,
                       input logic [15:0] t);
      @(negedge Clock);
      bus.iStall = s; bus.iJump = j; bus.iCall = c; bus.iRet = r; bus.iTarget = t;
      if (!s) begin
         if (m_valid && r) begin
            if (stk.size() == 0) begin
               m_pc = 16'd0; m_err = 1'b1;
            end else begin
               m_pc = stk.pop_back();
            end
            m_valid = 1'b0;
         end else if (m_valid && c) begin
            if (stk.size() < 8) stk.push_back(m_ipc + 16'd1);
            else m_err = 1'b1;
            m_pc = t; m_valid = 1'b0;
         end else if (m_valid && j) begin
            m_pc = t; m_valid = 1'b0;
         end else begin
            m_instr = rom(m_pc); m_ipc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 16'd1;
         end
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge Clock);
      Reset = 1'b0;
      bus.iStall = 0; bus.iJump = 0; bus.iCall = 0; bus.iRet = 0; bus.iTarget = 0;
      model_reset();
      @(posedge Clock);
      #1 Reset = 1'b1;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      bus.iStall = 0; bus.iJump = 0; bus.iCall = 0; bus.iRet = 0; bus.iTarget = 0;
      model_reset();
      #2;
      n_cmp++;
      if ({bus.oAddress, bus.oInstruction, bus.oInstrPC, bus.oValid, bus.oStackErr, bus.oDepth} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset.async got addr=%h instr=%h ipc=%h v=%b err=%b d=%0d want all zero",
                  bus.oAddress, bus.oInstruction, bus.oInstrPC, bus.oValid, bus.oStackErr, bus.oDepth);
      end
      @(posedge Clock);
      #1;
      n_cmp++;
      if (bus.oValid !== 1'b0 || bus.oAddress !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL reset.held got v=%b addr=%h want v=0 addr=0", bus.oValid, bus.oAddress);
      end
      Reset = 1'b1;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 17; i++) begin
         step(0, 0, 0, 0, 16'd0);
         n_cmp++;
         if (bus.oValid !== 1'b1 || bus.oInstrPC !== 16'(i)) begin
            n_fail++;
            $display("[TB] FAIL seq.pc got v=%b ipc=%h want v=1 ipc=%h", bus.oValid, bus.oInstrPC, 16'(i));
         end
         n_cmp++;
         if (bus.oInstruction !== m_instr || bus.oAddress !== m_pc) begin
            n_fail++;
            $display("[TB] FAIL seq.instr got instr=%h addr=%h want instr=%h addr=%h",
                     bus.oInstruction, bus.oAddress, m_instr, m_pc);
         end
      end
   endtask

   task automatic test_jump();
      int bubbles;
      bubbles = 0;
      for (int i = 0; i < 10; i++) begin
         if (m_valid && m_ipc == 16'd16) step(0, 1, 0, 0, 16'd15);
         else step(0, 0, 0, 0, 16'd0);
         if (!m_valid) bubbles++;
         n_cmp++;
         if (bus.oValid !== m_valid || bus.oAddress !== m_pc ||
             (m_valid && bus.oInstrPC !== m_ipc)) begin
            n_fail++;
            $display("[TB] FAIL jump.flow got v=%b addr=%h ipc=%h want v=%b addr=%h ipc=%h",
                     bus.oValid, bus.oAddress, bus.oInstrPC, m_valid, m_pc, m_ipc);
         end
      end
      n_cmp++;
      if (bus.oInstrPC !== 16'd15 && bus.oInstrPC !== 16'd16) begin
         n_fail++;
         $display("[TB] FAIL jump.loop got ipc=%h want 15 or 16", bus.oInstrPC);
      end
   endtask

   task automatic test_nested_call();
      int st;
      logic cmd;
      logic [3:0] want_depth [4];
      want_depth[0] = 4'd1; want_depth[1] = 4'd2; want_depth[2] = 4'd1; want_depth[3] = 4'd0;
      st = 0;
      for (int i = 0; i < 80 && st < 6; i++) begin
         cmd = 1'b1;
         if (st == 0 && m_valid) begin step(0, 1, 0, 0, 16'd5); st = 1; cmd = 1'b0; end
         else if (st == 1 && m_valid && m_ipc == 16'd5) begin step(0, 0, 1, 0, 16'd17); st = 2; end
         else if (st == 2 && m_valid && m_ipc == 16'd18) begin step(0, 0, 1, 0, 16'd30); st = 3; end
         else if (st == 3 && m_valid && m_ipc == 16'd31) begin step(0, 0, 0, 1, 16'd0); st = 4; end
         else if (st == 4 && m_valid && m_ipc == 16'd20) begin step(0, 0, 0, 1, 16'd0); st = 5; end
         else if (st == 5 && m_valid && m_ipc == 16'd7) begin st = 6; cmd = 1'b0; end
         else begin step(0, 0, 0, 0, 16'd0); cmd = 1'b0; end
         if (cmd) begin
            n_cmp++;
            if (bus.oDepth !== want_depth[st-2] || bus.oValid !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL nest.depth got d=%0d v=%b want d=%0d v=0",
                        bus.oDepth, bus.oValid, want_depth[st-2]);
            end
         end
         n_cmp++;
         if (bus.oValid !== m_valid || bus.oAddress !== m_pc || bus.oDepth !== 4'(stk.size()) ||
             (m_valid && (bus.oInstrPC !== m_ipc || bus.oInstruction !== m_instr))) begin
            n_fail++;
            $display("[TB] FAIL nest.flow got v=%b addr=%h ipc=%h d=%0d want v=%b addr=%h ipc=%h d=%0d",
                     bus.oValid, bus.oAddress, bus.oInstrPC, bus.oDepth, m_valid, m_pc, m_ipc, stk.size());
         end
      end
      n_cmp++;
      if (st != 6) begin
         n_fail++;
         $display("[TB] FAIL nest.timeout got phase=%0d want 6", st);
      end
   endtask

   task automatic test_overflow();
      int calls;
      logic [15:0] t;
      apply_reset();
      calls = 0;
      for (int i = 0; i < 60 && calls < 9; i++) begin
         if (m_valid) begin
            t = 16'(100 + 16 * calls);
            step(0, 0, 1, 0, t);
            calls++;
            n_cmp++;
            if (bus.oStackErr !== (calls == 9) || bus.oAddress !== t ||
                bus.oDepth !== 4'((calls > 8) ? 8 : calls)) begin
               n_fail++;
               $display("[TB] FAIL ovf.call%0d got err=%b addr=%h d=%0d want err=%b addr=%h",
                        calls, bus.oStackErr, bus.oAddress, bus.oDepth, calls == 9, t);
            end
         end else begin
            step(0, 0, 0, 0, 16'd0);
         end
      end
      n_cmp++;
      if (calls != 9 || bus.oDepth !== 4'd8) begin
         n_fail++;
         $display("[TB] FAIL ovf.final got calls=%0d d=%0d want 9 calls d=8", calls, bus.oDepth);
      end
      // Underflow from a fresh reset
      apply_reset();
      step(0, 0, 0, 0, 16'd0);
      step(0, 0, 0, 1, 16'd0);
      n_cmp++;
      if (bus.oAddress !== 16'd0 || bus.oStackErr !== 1'b1 || bus.oDepth !== 4'd0 || bus.oValid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL udf.ret got addr=%h err=%b d=%0d v=%b want addr=0 err=1 d=0 v=0",
                  bus.oAddress, bus.oStackErr, bus.oDepth, bus.oValid);
      end
      step(0, 0, 0, 0, 16'd0);
      n_cmp++;
      if (bus.oValid !== 1'b1 || bus.oInstrPC !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL udf.resume got v=%b ipc=%h want v=1 ipc=0", bus.oValid, bus.oInstrPC);
      end
   endtask

   task automatic test_stall();
      logic [15:0] held_pc;
      logic [15:0] held_ipc;
      step(0, 0, 0, 0, 16'd0);
      held_pc = m_pc; held_ipc = m_ipc;
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 0, 16'h0123);
         n_cmp++;
         if (bus.oAddress !== held_pc || bus.oInstrPC !== held_ipc || bus.oValid !== 1'b1 ||
             bus.oInstruction !== m_instr || bus.oDepth !== 4'(stk.size()) || bus.oStackErr !== m_err) begin
            n_fail++;
            $display("[TB] FAIL stall.hold got addr=%h ipc=%h v=%b want addr=%h ipc=%h v=1",
                     bus.oAddress, bus.oInstrPC, bus.oValid, held_pc, held_ipc);
         end
      end
      step(0, 0, 0, 0, 16'd0);
      n_cmp++;
      if (bus.oValid !== 1'b1 || bus.oInstrPC !== held_pc || bus.oAddress !== held_pc + 16'd1) begin
         n_fail++;
         $display("[TB] FAIL stall.release got v=%b ipc=%h want v=1 ipc=%h", bus.oValid, bus.oInstrPC, held_pc);
      end
   endtask

   task automatic test_wrap();
      if (!m_valid) step(0, 0, 0, 0, 16'd0);
      step(0, 1, 0, 0, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 16'd0);
         n_cmp++;
         if (bus.oValid !== 1'b1 || bus.oInstrPC !== 16'(16'hFFFE + i) || bus.oInstruction !== m_instr) begin
            n_fail++;
            $display("[TB] FAIL wrap.pc got v=%b ipc=%h instr=%h want v=1 ipc=%h instr=%h",
                     bus.oValid, bus.oInstrPC, bus.oInstruction, 16'(16'hFFFE + i), m_instr);
         end
      end
   endtask

   task automatic test_random();
      logic s, j, c, r;
      for (int i = 0; i < 400; i++) begin
         s = ($urandom_range(0, 4) == 0);
         j = ($urandom_range(0, 7) == 0);
         c = ($urandom_range(0, 7) == 0);
         r = ($urandom_range(0, 6) == 0);
         step(s, j, c, r, 16'($urandom_range(0, 255)));
         n_cmp++;
         if (bus.oValid !== m_valid || bus.oAddress !== m_pc || bus.oDepth !== 4'(stk.size()) ||
             bus.oStackErr !== m_err ||
             (m_valid && (bus.oInstrPC !== m_ipc || bus.oInstruction !== m_instr))) begin
            n_fail++;
            $display("[TB] FAIL rand.c%0d got v=%b addr=%h ipc=%h d=%0d err=%b want v=%b addr=%h ipc=%h d=%0d err=%b",
                     i, bus.oValid, bus.oAddress, bus.oInstrPC, bus.oDepth, bus.oStackErr,
                     m_valid, m_pc, m_ipc, stk.size(), m_err);
         end
      end
   endtask

   task automatic test_reset_mid();
      int calls;
      apply_reset();
      step(0, 0, 0, 0, 16'd0);
      step(0, 0, 0, 1, 16'd0);
      calls = 0;
      for (int i = 0; i < 40 && !(m_pc == 16'd40 && stk.size() == 2); i++) begin
         if (m_valid && calls < 2) begin
            step(0, 0, 1, 0, (calls == 0) ? 16'd30 : 16'd35);
            calls++;
         end else begin
            step(0, 0, 0, 0, 16'd0);
         end
      end
      n_cmp++;
      if (bus.oAddress !== 16'd40 || bus.oDepth !== 4'd2 || bus.oStackErr !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL rmid.setup got addr=%h d=%0d err=%b want addr=40 d=2 err=1",
                  bus.oAddress, bus.oDepth, bus.oStackErr);
      end
      @(negedge Clock);
      #2 Reset = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (bus.oAddress !== 16'd0 || bus.oValid !== 1'b0 || bus.oDepth !== 4'd0 || bus.oStackErr !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rmid.async got addr=%h v=%b d=%0d err=%b want all zero",
                  bus.oAddress, bus.oValid, bus.oDepth, bus.oStackErr);
      end
      @(posedge Clock);
      #1 Reset = 1'b1;
      step(0, 0, 0, 0, 16'd0);
      n_cmp++;
      if (bus.oValid !== 1'b1 || bus.oInstrPC !== 16'd0 || bus.oInstruction !== rom(16'd0)) begin
         n_fail++;
         $display("[TB] FAIL rmid.restart got v=%b ipc=%h instr=%h want v=1 ipc=0 instr=%h",
                  bus.oValid, bus.oInstrPC, bus.oInstruction, rom(16'd0));
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      salt   = 4'($urandom_range(0, 15));
      test_reset();
      test_sequential();
      test_jump();
      test_nested_call();
      test_stall();
      test_wrap();
      test_overflow();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
